photo_capture_ctrl: RTL

Control stage directly upstream of the VGA-side SRAM photo saver. It debounces the three user pushbuttons and frame-aligns the capture request. It drives the saver's take-frame, display-select and photo-index inputs, and tracks how many photos are stored. It runs in the VGA clock domain and consumes the saver's store-finish flag as the capture-complete handshake.

---
 rtl/photo_capture_ctrl_pkg.sv | 30 +++
 rtl/photo_capture_ctrl_if.sv | 26 ++
 rtl/photo_capture_ctrl_key_debounce.sv | 48 ++++
 rtl/photo_capture_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/photo_capture_ctrl_pkg.sv
// Shared definitions for the photo capture control slice.
// Holds the FSM state encodings, index width, default timing parameters
// and a small modulo-increment helper used for slot indices.
package photo_ctrl_pkg;

    localparam int unsigned IDX_W               = 4;
    localparam int unsigned STATE_W             = 3;
    localparam int unsigned FRAME_W             = 8;
    localparam int unsigned DEF_MAX_PHOTOS      = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_TIMEOUT_FRAMES  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_LIVE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_RELEASE = 3'd3,
        S_PLAY    = 3'd4
    } state_t;

    // idx + 1, wrapping to 0 once it reaches modulus (widened to avoid overflow).
    function automatic logic [IDX_W-1:0] idxInc(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] modulus);
        if (({1'b0, idx} + (IDX_W+1)'(1)) >= {1'b0, modulus})
            return IDX_W'(0);
        else
            return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/photo_capture_ctrl_if.sv
// Handshake bundle between the capture controller and the SRAM photo saver.
// master (controller): drives oTake_frame, oRead_Disp, oPhoto_Index,
//                      oPhoto_Count, oError, oState; samples iStore_finish.
// slave  (saver side): the mirror image.
interface photo_capture_ctrl_if;
    import photo_ctrl_pkg::*;

    logic               oTake_frame;
    logic               oRead_Disp;
    logic [IDX_W-1:0]   oPhoto_Index;
    logic [IDX_W-1:0]   oPhoto_Count;
    logic               oError;
    logic [STATE_W-1:0] oState;
    logic               iStore_finish;

    modport master (
        output oTake_frame, oRead_Disp, oPhoto_Index, oPhoto_Count, oError, oState,
        input  iStore_finish
    );

    modport slave (
        input  oTake_frame, oRead_Disp, oPhoto_Index, oPhoto_Count, oError, oState,
        output iStore_finish
    );

endinterface

// File: rtl/photo_capture_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and press pulse.
// Ports: iCLK, iRST_N (async active-low), iKEY_N (raw active-low key),
//        oPress_c (one-cycle press pulse, combinational from registered state).
// The pulse is raised in the cycle the debounced level commits to 0, so a
// stable raw edge reaches the consumer's registers DEBOUNCE_CYCLES+2 edges later.
module key_debounce
    import photo_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iKEY_N,
    output logic oPress_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta;
    logic             syncKey;
    logic             keyLevel;
    logic [CNT_W-1:0] stableCnt;

    // Keys idle high, so synchroniser and debounced level reset to released.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            syncMeta  <= 1'b1;
            syncKey   <= 1'b1;
            keyLevel  <= 1'b1;
            stableCnt <= '0;
        end else begin
            syncMeta <= iKEY_N;
            syncKey  <= syncMeta;
            if (syncKey == keyLevel) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                keyLevel  <= syncKey;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CNT_W'(1);
            end
        end
    end

    assign oPress_c = (syncKey != keyLevel) && (stableCnt == CNT_LAST) && !syncKey;

endmodule

// File: rtl/photo_capture_ctrl.sv
// Capture controller sitting in front of the VGA-side SRAM photo saver.
// Debounces SHOT/MODE/NEXT keys, aligns capture to a VSYNC falling edge,
// drives take-frame / display-select / photo-index and tracks stored photos.
// Ports: iCLK, iRST_N (async active-low), iKEY_SHOT_N, iKEY_MODE_N,
//        iKEY_NEXT_N (raw active-low keys), iVGA_VSYNC_N, saver (master
//        modport: oTake_frame, oRead_Disp, oPhoto_Index, oPhoto_Count,
//        oError, oState out; iStore_finish in).
// Build option: PHOTO_CAPTURE_AUTO_PLAY_EN -- after a capture, go straight to
// playback showing the slot just written instead of returning to live view.
module photo_capture_ctrl
    import photo_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PHOTOS      = DEF_MAX_PHOTOS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_FRAMES  = DEF_TIMEOUT_FRAMES
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iKEY_SHOT_N,
    input  logic                 iKEY_MODE_N,
    input  logic                 iKEY_NEXT_N,
    input  logic                 iVGA_VSYNC_N,
    photo_capture_ctrl_if.master saver
);

    localparam logic [IDX_W-1:0]   MAX_IDX    = IDX_W'(MAX_PHOTOS);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(MAX_PHOTOS - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(TIMEOUT_FRAMES - 1);

    logic shotPress_c, modePress_c, nextPress_c;
    logic shotEv_c, modeEv_c, nextEv_c;
    logic vsPrev, vsFall_c;

    state_t             state;
    logic [IDX_W-1:0]   wrIdx;
    logic [IDX_W-1:0]   pendIdx;
    logic [IDX_W-1:0]   photoIndex;
    logic [IDX_W-1:0]   photoCount;
    logic [FRAME_W-1:0] frameCnt;
    logic               takeFrame;
    logic               readDisp;
    logic               errFlag;

    logic [IDX_W-1:0]   prevIdx_c;
    logic [IDX_W-1:0]   wrIdxInc_c;
    logic [IDX_W-1:0]   pendInc_c;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKeyShot (
        .iCLK(iCLK), .iRST_N(iRST_N), .iKEY_N(iKEY_SHOT_N), .oPress_c(shotPress_c)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKeyMode (
        .iCLK(iCLK), .iRST_N(iRST_N), .iKEY_N(iKEY_MODE_N), .oPress_c(modePress_c)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKeyNext (
        .iCLK(iCLK), .iRST_N(iRST_N), .iKEY_N(iKEY_NEXT_N), .oPress_c(nextPress_c)
    );

    // Fixed priority SHOT > MODE > NEXT; losers are simply dropped.
    assign shotEv_c = shotPress_c;
    assign modeEv_c = modePress_c && !shotPress_c;
    assign nextEv_c = nextPress_c && !shotPress_c && !modePress_c;

    assign vsFall_c   = vsPrev && !iVGA_VSYNC_N;
    assign prevIdx_c  = (wrIdx == '0) ? LAST_IDX : wrIdx - IDX_W'(1);
    assign wrIdxInc_c = idxInc(wrIdx, MAX_IDX);
    assign pendInc_c  = idxInc(pendIdx, photoCount);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vsPrev <= 1'b1;
        end else begin
            vsPrev <= iVGA_VSYNC_N;
        end
    end

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_LIVE;
            wrIdx      <= '0;
            pendIdx    <= '0;
            photoIndex <= '0;
            photoCount <= '0;
            frameCnt   <= '0;
            takeFrame  <= 1'b0;
            readDisp   <= 1'b0;
            errFlag    <= 1'b0;
        end else begin
            case (state)
                S_LIVE: begin
                    readDisp   <= 1'b0;
                    photoIndex <= wrIdx;
                    if (shotEv_c) begin
                        state   <= S_ARM;
                        errFlag <= 1'b0;
                    end else if (modeEv_c && (photoCount != '0)) begin
                        state      <= S_PLAY;
                        readDisp   <= 1'b1;
                        pendIdx    <= prevIdx_c;
                        photoIndex <= prevIdx_c;
                    end
                end

                S_ARM: begin
                    if (vsFall_c) begin
                        state     <= S_CAPTURE;
                        takeFrame <= 1'b1;
                        frameCnt  <= '0;
                    end
                end

                S_CAPTURE: begin
                    // A finished store wins over a timeout landing on the same cycle.
                    if (saver.iStore_finish) begin
                        state     <= S_RELEASE;
                        takeFrame <= 1'b0;
                    end else if (vsFall_c) begin
                        if (frameCnt == LAST_FRAME) begin
                            state     <= S_LIVE;
                            takeFrame <= 1'b0;
                            errFlag   <= 1'b1;
                        end else begin
                            frameCnt <= frameCnt + FRAME_W'(1);
                        end
                    end
                end

                S_RELEASE: begin
                    takeFrame <= 1'b0;
                    if (!saver.iStore_finish) begin
                        wrIdx <= wrIdxInc_c;
                        if (photoCount != MAX_IDX)
                            photoCount <= photoCount + IDX_W'(1);
`ifdef PHOTO_CAPTURE_AUTO_PLAY_EN
                        state      <= S_PLAY;
                        readDisp   <= 1'b1;
                        pendIdx    <= wrIdx;
                        photoIndex <= wrIdx;
`else
                        state      <= S_LIVE;
                        photoIndex <= wrIdxInc_c;
`endif
                    end
                end

                S_PLAY: begin
                    if (modeEv_c) begin
                        state      <= S_LIVE;
                        readDisp   <= 1'b0;
                        photoIndex <= wrIdx;
                    end else begin
                        // Displayed index only moves on a frame boundary to avoid tearing.
                        if (nextEv_c)
                            pendIdx <= pendInc_c;
                        if (vsFall_c)
                            photoIndex <= nextEv_c ? pendInc_c : pendIdx;
                    end
                end

                default: begin
                    state      <= S_LIVE;
                    takeFrame  <= 1'b0;
                    readDisp   <= 1'b0;
                    photoIndex <= wrIdx;
                end
            endcase
        end
    end

    assign saver.oTake_frame  = takeFrame;
    assign saver.oRead_Disp   = readDisp;
    assign saver.oPhoto_Index = photoIndex;
    assign saver.oPhoto_Count = photoCount;
    assign saver.oError       = errFlag;
    assign saver.oState       = state;

endmodule
